grey_scale_bank: RTL and testbench

Parametrised bank of free-running grey-code counters sharing one clock, each stepping at its own programmable sub-rate through a per-channel prescaler. Rate scaling uses clock enables instead of generated clocks, so every channel stays in the `clk` domain and no derived clocks are needed. Each channel also supports up/down count and a synchronous clear. The block sits beside the reset conditioner and drives the grey-code observation outputs.

---
 rtl/grey_scale_bank_if.sv | 25 ++
 rtl/grey_scale_bank.sv | 103 ++++++++++
 tb/tb_grey_scale_bank.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/grey_scale_bank_if.sv
// Channel-bus interface for grey_scale_bank: per-channel controls in, grey/tick/wrap/err out.
interface grey_scale_bank_if #(
  parameter int unsigned WIDTH    = 6,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DIV_W    = 4
);
  logic [CHANNELS-1:0]       en;
  logic [CHANNELS-1:0]       dir;
  logic [CHANNELS-1:0]       clr;
  logic [CHANNELS*DIV_W-1:0] div;
  logic [CHANNELS*WIDTH-1:0] grey;
  logic [CHANNELS-1:0]       tick;
  logic [CHANNELS-1:0]       wrap;
  logic                      err;

  modport master (
    output en, dir, clr, div,
    input  grey, tick, wrap, err
  );

  modport slave (
    input  en, dir, clr, div,
    output grey, tick, wrap, err
  );
endinterface

// File: rtl/grey_scale_bank.sv
// Bank of clock-enabled grey-code counters with per-channel prescaler, direction and clear.
// Optional grey-property checker is built when GREY_SCALE_CHECK_EN is defined.
module grey_scale_bank #(
  parameter int unsigned WIDTH    = 6,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DIV_W    = 4
) (
  input logic               clk_i,
  input logic               rst_i,
  grey_scale_bank_if.slave  bus
);

  logic [CHANNELS-1:0][DIV_W-1:0] p_q, p_d;
  logic [CHANNELS-1:0][WIDTH-1:0] b_q, b_d;
  logic [CHANNELS-1:0][WIDTH-1:0] grey_q, grey_d;
  logic [CHANNELS-1:0][WIDTH-1:0] nb;
  logic [CHANNELS-1:0]            tick_q, tick_d;
  logic [CHANNELS-1:0]            wrap_q, wrap_d;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      p_d[i]    = p_q[i];
      b_d[i]    = b_q[i];
      grey_d[i] = grey_q[i];
      tick_d[i] = 1'b0;
      wrap_d[i] = 1'b0;
      nb[i]     = bus.dir[i] ? b_q[i] + 1'b1 : b_q[i] - 1'b1;
      if (bus.clr[i]) begin
        p_d[i]    = '0;
        b_d[i]    = '0;
        grey_d[i] = '0;
      end else if (bus.en[i]) begin
        // >= so that lowering div below the running count forces an immediate step
        if (p_q[i] >= bus.div[i*DIV_W +: DIV_W]) begin
          p_d[i]    = '0;
          b_d[i]    = nb[i];
          grey_d[i] = nb[i] ^ (nb[i] >> 1);
          tick_d[i] = 1'b1;
          wrap_d[i] = bus.dir[i] ? (nb[i] == '0) : (nb[i] == '1);
        end else begin
          p_d[i] = p_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p_q    <= '0;
      b_q    <= '0;
      grey_q <= '0;
      tick_q <= '0;
      wrap_q <= '0;
    end else begin
      p_q    <= p_d;
      b_q    <= b_d;
      grey_q <= grey_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.grey = grey_q;
  assign bus.tick = tick_q;
  assign bus.wrap = wrap_q;

`ifdef GREY_SCALE_CHECK_EN
  logic [CHANNELS-1:0][WIDTH-1:0] prev_q;
  logic [CHANNELS-1:0][WIDTH-1:0] diff;
  logic [CHANNELS-1:0]            clr_prev_q;
  logic                           err_q, err_d;

  // Observes the output net itself so any disturbance of grey is caught.
  always_comb begin
    err_d = err_q;
    for (int i = 0; i < CHANNELS; i++) begin
      diff[i] = bus.grey[i*WIDTH +: WIDTH] ^ prev_q[i];
      if (!bus.clr[i] && !clr_prev_q[i]) begin
        if (((diff[i] & (diff[i] - 1'b1)) != '0) || ((diff[i] != '0) && !tick_q[i])) begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q     <= '0;
      clr_prev_q <= '0;
      err_q      <= 1'b0;
    end else begin
      prev_q     <= bus.grey;
      clr_prev_q <= bus.clr;
      err_q      <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_grey_scale_bank.sv
// Self-checking bench for grey_scale_bank: directed scenarios plus a randomized run
// against an arithmetic reference model of each channel.
module tb_grey_scale_bank;
  localparam int W = 6;
  localparam int C = 4;
  localparam int D = 4;
  localparam int M = 1 << W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  grey_scale_bank_if #(.WIDTH(W), .CHANNELS(C), .DIV_W(D)) ifc ();

  grey_scale_bank #(.WIDTH(W), .CHANNELS(C), .DIV_W(D)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc.slave)
  );

  // Reference model: count of enabled cycles since last step, and integer position.
  int       m_acc [C];
  int       m_pos [C];
  logic [W-1:0] m_g [C];
  bit       m_t [C];
  bit       m_w [C];

  function automatic logic [W-1:0] to_grey(input int v);
    logic [W-1:0] b;
    b = v[W-1:0];
    return b ^ (b >> 1);
  endfunction

  function automatic logic [W-1:0] grey_of(input int ch);
    logic [C*W-1:0] g;
    g = ifc.grey;
    return g[ch*W +: W];
  endfunction

  task automatic cycle();
    @(posedge clk);
    for (int c = 0; c < C; c++) begin
      int dv;
      dv = int'(ifc.div[c*D +: D]);
      m_t[c] = 1'b0;
      m_w[c] = 1'b0;
      if (rst || ifc.clr[c]) begin
        m_acc[c] = 0;
        m_pos[c] = 0;
        m_g[c]   = '0;
      end else if (ifc.en[c]) begin
        if (m_acc[c] >= dv) begin
          m_acc[c] = 0;
          m_pos[c] = ifc.dir[c] ? (m_pos[c] + 1) % M : (m_pos[c] + M - 1) % M;
          m_g[c]   = to_grey(m_pos[c]);
          m_t[c]   = 1'b1;
          m_w[c]   = ifc.dir[c] ? (m_pos[c] == 0) : (m_pos[c] == M - 1);
        end else begin
          m_acc[c] = m_acc[c] + 1;
        end
      end
    end
    #1;
  endtask

  task automatic set_div(input int ch, input int v);
    logic [D-1:0] f;
    f = v[D-1:0];
    ifc.div[ch*D +: D] = f;
  endtask

  task automatic apply_reset();
    ifc.en  = '0;
    ifc.clr = '0;
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.en  = '1;
    ifc.clr = '0;
    ifc.dir = '1;
    ifc.div = '0;
    cycle();
    cycle();
    for (int c = 0; c < C; c++) begin
      total++;
      if (grey_of(c) !== '0 || ifc.tick[c] !== 1'b0 || ifc.wrap[c] !== 1'b0) begin
        bad++;
        $display("FAIL reset ch%0d got grey=%h tick=%b wrap=%b want 0/0/0",
                 c, grey_of(c), ifc.tick[c], ifc.wrap[c]);
      end
    end
    total++;
    if (ifc.err !== 1'b0) begin
      bad++;
      $display("FAIL reset_err got=%b want=0", ifc.err);
    end
    rst = 1'b0;
    ifc.div = '1;
    cycle();
    for (int c = 0; c < C; c++) begin
      total++;
      if (grey_of(c) !== '0 || ifc.tick[c] !== 1'b0) begin
        bad++;
        $display("FAIL post_reset ch%0d got grey=%h tick=%b want 0/0", c, grey_of(c), ifc.tick[c]);
      end
    end
  endtask

  task automatic test_up_div1();
    apply_reset();
    set_div(0, 0);
    ifc.dir[0] = 1'b1;
    ifc.en = 4'b0001;
    for (int k = 1; k <= 64; k++) begin
      cycle();
      total++;
      if (grey_of(0) !== to_grey(k % 64) || ifc.tick[0] !== 1'b1 || ifc.wrap[0] !== (k == 64)) begin
        bad++;
        $display("FAIL up_div1 step%0d got grey=%h tick=%b wrap=%b want grey=%h tick=1 wrap=%b",
                 k, grey_of(0), ifc.tick[0], ifc.wrap[0], to_grey(k % 64), (k == 64));
      end
    end
  endtask

  task automatic test_mixed_rates();
    apply_reset();
    set_div(1, 3);
    set_div(2, 7);
    ifc.dir[1] = 1'b1;
    ifc.dir[2] = 1'b0;
    ifc.en = 4'b0110;
    for (int n = 1; n <= 32; n++) begin
      cycle();
      total++;
      if (ifc.tick[1] !== (n % 4 == 0) || grey_of(1) !== to_grey(n / 4)) begin
        bad++;
        $display("FAIL mixed_ch1 cyc%0d got tick=%b grey=%h want tick=%b grey=%h",
                 n, ifc.tick[1], grey_of(1), (n % 4 == 0), to_grey(n / 4));
      end
      total++;
      if (ifc.tick[2] !== (n % 8 == 0)) begin
        bad++;
        $display("FAIL mixed_ch2_tick cyc%0d got=%b want=%b", n, ifc.tick[2], (n % 8 == 0));
      end
      if (n == 8) begin
        total++;
        if (grey_of(2) !== 6'b100000 || ifc.wrap[2] !== 1'b1) begin
          bad++;
          $display("FAIL mixed_ch2_first got grey=%b wrap=%b want 100000/1", grey_of(2), ifc.wrap[2]);
        end
      end
      if (n == 16) begin
        total++;
        if (grey_of(2) !== 6'b100001 || ifc.wrap[2] !== 1'b0) begin
          bad++;
          $display("FAIL mixed_ch2_second got grey=%b wrap=%b want 100001/0", grey_of(2), ifc.wrap[2]);
        end
      end
    end
  endtask

  task automatic test_rate_change_clr();
    apply_reset();
    set_div(3, 7);
    ifc.dir[3] = 1'b1;
    ifc.en = 4'b1000;
    for (int n = 0; n < 5; n++) cycle();
    total++;
    if (ifc.tick[3] !== 1'b0) begin
      bad++;
      $display("FAIL rate_pre tick got=%b want=0", ifc.tick[3]);
    end
    set_div(3, 2);
    for (int n = 1; n <= 7; n++) begin
      cycle();
      total++;
      if (ifc.tick[3] !== (n == 1 || n == 4 || n == 7)) begin
        bad++;
        $display("FAIL rate_drop cyc%0d tick got=%b want=%b", n, ifc.tick[3], (n == 1 || n == 4 || n == 7));
      end
    end
    total++;
    if (grey_of(3) !== 6'b000010) begin
      bad++;
      $display("FAIL rate_grey got=%b want=000010", grey_of(3));
    end
    cycle();
    cycle();
    ifc.clr[3] = 1'b1;
    cycle();
    ifc.clr[3] = 1'b0;
    total++;
    if (grey_of(3) !== '0 || ifc.tick[3] !== 1'b0 || ifc.wrap[3] !== 1'b0) begin
      bad++;
      $display("FAIL clr_priority got grey=%b tick=%b wrap=%b want 0/0/0",
               grey_of(3), ifc.tick[3], ifc.wrap[3]);
    end
  endtask

  task automatic test_enable_dir();
    apply_reset();
    set_div(0, 0);
    set_div(1, 5);
    ifc.dir[1:0] = 2'b11;
    ifc.en = 4'b0011;
    for (int n = 0; n < 4; n++) cycle();
    total++;
    if (grey_of(0) !== 6'b000110) begin
      bad++;
      $display("FAIL en_pre grey got=%b want=000110", grey_of(0));
    end
    ifc.en = '0;
    for (int n = 0; n < 10; n++) begin
      cycle();
      total++;
      if (grey_of(0) !== 6'b000110 || ifc.tick[0] !== 1'b0 || ifc.tick[1] !== 1'b0) begin
        bad++;
        $display("FAIL en_hold cyc%0d got grey=%b tick=%b%b want 000110 tick=00",
                 n, grey_of(0), ifc.tick[1], ifc.tick[0]);
      end
    end
    ifc.en = 4'b0011;
    ifc.dir[0] = 1'b0;
    cycle();
    total++;
    if (grey_of(0) !== 6'b000010 || ifc.tick[1] !== 1'b0) begin
      bad++;
      $display("FAIL dir_rev1 got grey=%b ch1tick=%b want 000010/0", grey_of(0), ifc.tick[1]);
    end
    cycle();
    total++;
    if (grey_of(0) !== 6'b000011 || ifc.tick[1] !== 1'b1) begin
      bad++;
      $display("FAIL dir_rev2 got grey=%b ch1tick=%b want 000011/1", grey_of(0), ifc.tick[1]);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 1000; n++) begin
      for (int c = 0; c < C; c++) begin
        ifc.en[c]  = ($urandom_range(0, 3) != 0);
        ifc.dir[c] = ($urandom_range(0, 7) != 0) ? ifc.dir[c] : ~ifc.dir[c];
        ifc.clr[c] = ($urandom_range(0, 31) == 0);
        if ($urandom_range(0, 15) == 0) set_div(c, int'($urandom_range(0, (1 << D) - 1)));
      end
      cycle();
      for (int c = 0; c < C; c++) begin
        total++;
        if (grey_of(c) !== m_g[c] || ifc.tick[c] !== m_t[c] || ifc.wrap[c] !== m_w[c]) begin
          bad++;
          $display("FAIL random cyc%0d ch%0d got grey=%h tick=%b wrap=%b want grey=%h tick=%b wrap=%b",
                   n, c, grey_of(c), ifc.tick[c], ifc.wrap[c], m_g[c], m_t[c], m_w[c]);
        end
      end
      total++;
      if (ifc.err !== 1'b0) begin
        bad++;
        $display("FAIL random_err cyc%0d got=%b want=0", n, ifc.err);
      end
    end
    ifc.clr = '0;
  endtask

`ifdef GREY_SCALE_CHECK_EN
  task automatic test_checker();
    logic [C*W-1:0] fv;
    apply_reset();
    ifc.en = '0;
    cycle();
    fv = ifc.grey ^ {{(C*W-2){1'b0}}, 2'b11};
    force ifc.grey = fv;
    cycle();
    release ifc.grey;
    total++;
    if (ifc.err !== 1'b1) begin
      bad++;
      $display("FAIL checker_set got=%b want=1", ifc.err);
    end
    for (int n = 0; n < 5; n++) cycle();
    total++;
    if (ifc.err !== 1'b1) begin
      bad++;
      $display("FAIL checker_sticky got=%b want=1", ifc.err);
    end
    apply_reset();
    total++;
    if (ifc.err !== 1'b0) begin
      bad++;
      $display("FAIL checker_rst got=%b want=0", ifc.err);
    end
  endtask
`endif

  initial begin
    for (int c = 0; c < C; c++) begin
      m_acc[c] = 0;
      m_pos[c] = 0;
      m_g[c]   = '0;
      m_t[c]   = 1'b0;
      m_w[c]   = 1'b0;
    end
    ifc.en  = '0;
    ifc.dir = '1;
    ifc.clr = '0;
    ifc.div = '0;
    test_reset();
    test_up_div1();
    test_mixed_rates();
    test_rate_change_clr();
    test_enable_dir();
    test_random();
`ifdef GREY_SCALE_CHECK_EN
    test_checker();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
